system_pio_in_capture: RTL

//   Avalon-MM slave input port with edge capture and interrupt. It is the read-side

---
 rtl/system_pio_in_capture.sv | 104 ++++++++++
 1 files changed

// File: rtl/system_pio_in_capture.sv
// Avalon-MM input port: synchronises in_port, latches selected edges per bit into
// W1C capture flags and raises a level IRQ from the masked flags.

module system_pio_in_capture_lane #(
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_in,
    input  logic i_clr,
    output logic o_sync,
    output logic o_cap
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_cap;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_cap  = r_cap;
    assign w_rise = o_sync & ~r_prev;
    assign w_fall = ~o_sync & r_prev;

    always_comb begin
        case (EDGE_TYPE)
            0:       w_edge = w_rise;
            1:       w_edge = w_fall;
            default: w_edge = w_rise | w_fall;
        endcase
    end

    // prev resets low, so an input held high across reset release reports one rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_cap  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            r_prev <= o_sync;
            r_cap  <= w_edge | (r_cap & ~i_clr);
        end
    end
endmodule

module system_pio_in_capture #(
    parameter int WIDTH       = 8,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic             w_wr;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_cap;
    logic [WIDTH-1:0] r_mask;
    logic             w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_clr    = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign w_unused = &{1'b0, writedata};

    system_pio_in_capture_lane #(
        .EDGE_TYPE  (EDGE_TYPE),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lane [WIDTH-1:0] (
        .clk    (clk),
        .reset_n(reset_n),
        .i_in   (in_port),
        .i_clr  (w_clr),
        .o_sync (w_sync),
        .o_cap  (w_cap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                   r_mask <= '0;
        else if (w_wr && address == 2'd1) r_mask <= writedata[WIDTH-1:0];
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = w_sync;
            2'd1:    readdata[WIDTH-1:0] = r_mask;
            2'd3:    readdata[WIDTH-1:0] = w_cap;
            default: readdata = '0;
        endcase
    end

    // Driven only from flops, so no decode glitches reach the IRQ line
    assign irq = |(w_cap & r_mask);
endmodule
